cache_arbiter: RTL and testbench

Arbitrates the split L1 caches' line-fill and write-back traffic onto the single shared physical-memory port. It sits below the instruction cache (fetch stage) and the data cache (MEM stage) and above physical memory / L2. It serialises one full-line transaction at a time. When both caches are waiting, service alternates round-robin so that neither fetch nor MEM stalls forever.

---
 rtl/cache_arbiter_if.sv | 45 ++++
 rtl/cache_arbiter.sv | 116 +++++++++++
 tb/tb_cache_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the split L1 caches, the arbiter and physical memory.
// master: the arbiter's view (drives resps, line data and the pmem strobes).
// slave:  the environment's view (caches and memory).
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    // I-cache side
    logic                  icache_read;
    logic [ADDR_WIDTH-1:0] icache_address;
    logic [LINE_WIDTH-1:0] icache_rdata;
    logic                  icache_resp;
    // D-cache side
    logic                  dcache_read;
    logic                  dcache_write;
    logic [ADDR_WIDTH-1:0] dcache_address;
    logic [LINE_WIDTH-1:0] dcache_wdata;
    logic [LINE_WIDTH-1:0] dcache_rdata;
    logic                  dcache_resp;
    // Physical memory side
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        input  icache_read, icache_address,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  pmem_rdata, pmem_resp,
        output icache_rdata, icache_resp,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output icache_read, icache_address,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        output pmem_rdata, pmem_resp,
        input  icache_rdata, icache_resp,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Serialises I-cache line fills and D-cache fills/write-backs onto one
// physical-memory port, one full line at a time. Ties alternate between the
// two caches so neither fetch nor MEM can be starved.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    cache_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Transaction latched at grant; requester inputs are ignored after that.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] wdata;
        logic                  is_write;
    } txn_t;

    state_t                state;
    txn_t                  txn;
    logic                  last_grant_d;  // 0: I-cache won last, 1: D-cache
    logic [LINE_WIDTH-1:0] line_buf;      // shared return line for both caches
    logic                  pmem_read_q;
    logic                  pmem_write_q;
    logic                  icache_resp_q;
    logic                  dcache_resp_q;

    logic i_pend;
    logic d_pend;
    logic grant_d;

    // A write-back wins over a simultaneous D-cache read; the read is dropped.
    // On a tie the requester that did not win last time gets the port.
    assign i_pend  = bus.icache_read;
    assign d_pend  = bus.dcache_read | bus.dcache_write;
    assign grant_d = d_pend & (~i_pend | ~last_grant_d);

    // Arbitration FSM; every output is a register so strobes drop with rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            txn           <= '0;
            last_grant_d  <= 1'b0;
            line_buf      <= '0;
            pmem_read_q   <= 1'b0;
            pmem_write_q  <= 1'b0;
            icache_resp_q <= 1'b0;
            dcache_resp_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_pend | d_pend) begin
                        last_grant_d <= grant_d;
                        if (grant_d) begin
                            txn.addr     <= bus.dcache_address;
                            txn.is_write <= bus.dcache_write;
                            if (bus.dcache_write) begin
                                txn.wdata <= bus.dcache_wdata;
                            end
                            pmem_read_q  <= ~bus.dcache_write;
                            pmem_write_q <= bus.dcache_write;
                            state        <= D_BUSY;
                        end else begin
                            txn.addr     <= bus.icache_address;
                            txn.is_write <= 1'b0;
                            pmem_read_q  <= 1'b1;
                            pmem_write_q <= 1'b0;
                            state        <= I_BUSY;
                        end
                    end
                end
                I_BUSY, D_BUSY: begin
                    // No timeout: memory may take as long as it needs.
                    if (bus.pmem_resp) begin
                        if (!txn.is_write) begin
                            line_buf <= bus.pmem_rdata;
                        end
                        icache_resp_q <= (state == I_BUSY);
                        dcache_resp_q <= (state == D_BUSY);
                        pmem_read_q   <= 1'b0;
                        pmem_write_q  <= 1'b0;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    // One-cycle pulse gives the requester time to drop its
                    // level request before the next arbitration.
                    icache_resp_q <= 1'b0;
                    dcache_resp_q <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = txn.addr;
    assign bus.pmem_wdata   = txn.wdata;
    assign bus.icache_resp  = icache_resp_q;
    assign bus.dcache_resp  = dcache_resp_q;
    assign bus.icache_rdata = line_buf;
    assign bus.dcache_rdata = line_buf;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed scenarios followed by random
// traffic from both caches against a latency-randomised memory model.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();
    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic          w;
        logic [LW-1:0] data;
    } exp_t;

    int n_pass  = 0;
    int n_total = 0;

    // memory model controls
    int            force_lat  = 0;   // 0: random 1..4
    int            spur_pct   = 0;   // chance of pmem_resp while no strobe
    bit            fill_fixed = 0;
    logic [LW-1:0] fixed_line = '0;

    // reference model state
    exp_t          iq[$];
    exp_t          dq[$];
    bit            glog[$];          // grant history, 1 = D-cache
    bit            last_d;
    logic [LW-1:0] model_line;

    // previous-negedge samples
    logic          p_iread, p_dread, p_dwrite, p_strobe, p_presp, p_resp, p_rst;
    logic [AW-1:0] p_iaddr, p_daddr;
    logic [LW-1:0] p_dwdata;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
        logic [LW-1:0] l;
        if (fill_fixed) return fixed_line;
        for (int j = 0; j < LW / 32; j++) l[j*32 +: 32] = ((a ^ (32'h1000_0001 * j)) * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        return l;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int j = 0; j < LW / 32; j++) l[j*32 +: 32] = $urandom;
        return l;
    endfunction

    // Memory: answers each strobe after a chosen latency, sometimes pulses
    // pmem_resp with junk data while no transaction is open.
    initial begin : memory
        int cnt;
        int lat;
        cnt = 0;
        lat = 1;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = rand_line();
            if (rst) begin
                cnt = 0;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (cnt == 0) lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
                cnt++;
                if (cnt >= lat) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read) bus.pmem_rdata = mem_line(bus.pmem_address);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (int'($urandom_range(0, 99)) < spur_pct) bus.pmem_resp = 1'b1;
            end
        end
    end

    // Monitor: predicts each grant from the request levels the arbiter saw,
    // queues the expected response, and checks responses as they appear.
    initial begin : monitor
        logic strobe, anyresp, i_pend, d_pend, gd, prev_idle;
        exp_t e;
        p_iread = 0; p_dread = 0; p_dwrite = 0; p_strobe = 0; p_presp = 0; p_resp = 0; p_rst = 1;
        p_iaddr = '0; p_daddr = '0; p_dwdata = '0;
        last_d = 0;
        model_line = '0;
        forever begin
            @(negedge clk);
            strobe  = bus.pmem_read | bus.pmem_write;
            anyresp = bus.icache_resp | bus.dcache_resp;
            if (rst) begin
                iq.delete();
                dq.delete();
                last_d = 0;
                model_line = '0;
            end else begin
                i_pend    = p_iread;
                d_pend    = p_dread | p_dwrite;
                prev_idle = !p_rst && !p_strobe && !p_resp;
                if (strobe && !p_strobe) begin
                    chk("grant_from_idle", prev_idle && (i_pend || d_pend), 1);
                    gd = d_pend && (!i_pend || !last_d);
                    last_d = gd;
                    glog.push_back(gd);
                    if (gd) begin
                        chk("d_addr", bus.pmem_address, p_daddr);
                        chk("d_strobes", {bus.pmem_read, bus.pmem_write}, p_dwrite ? 2'b01 : 2'b10);
                        if (p_dwrite) chk("d_wdata", bus.pmem_wdata, p_dwdata);
                        else model_line = mem_line(p_daddr);
                        e.w = p_dwrite;
                        e.data = model_line;
                        dq.push_back(e);
                    end else begin
                        chk("i_addr", bus.pmem_address, p_iaddr);
                        chk("i_strobes", {bus.pmem_read, bus.pmem_write}, 2'b10);
                        model_line = mem_line(p_iaddr);
                        e.w = 0;
                        e.data = model_line;
                        iq.push_back(e);
                    end
                end else if (prev_idle && (i_pend || d_pend)) begin
                    chk("grant_latency", strobe, 1);
                end
                if (p_strobe && !strobe) chk("strobe_held_until_pmem_resp", p_presp, 1);
                if (anyresp) begin
                    chk("resp_onehot", bus.icache_resp & bus.dcache_resp, 0);
                    chk("resp_single_cycle", p_resp, 0);
                    chk("resp_after_pmem_resp", p_presp & p_strobe, 1);
                    chk("strobes_low_in_resp", strobe, 0);
                    if (bus.icache_resp) begin
                        chk("i_resp_expected", iq.size() != 0, 1);
                        if (iq.size() != 0) begin
                            e = iq.pop_front();
                            chk("i_rdata", bus.icache_rdata, e.data);
                        end
                    end
                    if (bus.dcache_resp) begin
                        chk("d_resp_expected", dq.size() != 0, 1);
                        if (dq.size() != 0) begin
                            e = dq.pop_front();
                            chk(e.w ? "d_rdata_after_write" : "d_rdata", bus.dcache_rdata, e.data);
                        end
                    end
                end
            end
            p_iread  = bus.icache_read;
            p_dread  = bus.dcache_read;
            p_dwrite = bus.dcache_write;
            p_iaddr  = bus.icache_address;
            p_daddr  = bus.dcache_address;
            p_dwdata = bus.dcache_wdata;
            p_strobe = strobe;
            p_presp  = bus.pmem_resp;
            p_resp   = anyresp;
            p_rst    = rst;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_icache_resp", bus.icache_resp, 0);
        chk("rst_dcache_resp", bus.dcache_resp, 0);
        chk("rst_pmem_address", bus.pmem_address, 0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 0);
        chk("rst_icache_rdata", bus.icache_rdata, 0);
        chk("rst_dcache_rdata", bus.dcache_rdata, 0);
        rst = 1'b0;
    endtask

    // Request already raised in cycle 0; counts strobe cycles until the resp.
    task automatic run_txn(input bit want_d, input int max_cyc, output int rd, output int wr, output int lat);
        rd = 0; wr = 0; lat = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk); #1;
            if (bus.pmem_read) rd++;
            if (bus.pmem_write) wr++;
            if (want_d ? bus.dcache_resp : bus.icache_resp) begin
                lat = c;
                break;
            end
        end
        if (want_d) begin bus.dcache_read = 0; bus.dcache_write = 0; end
        else bus.icache_read = 0;
    endtask

    task automatic drive_i(input int n);
        bit ok;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            bus.icache_address = $urandom;
            bus.icache_read = 1;
            ok = 0;
            for (int c = 0; c < 100; c++) begin
                @(posedge clk); #1;
                if (bus.icache_resp) begin ok = 1; break; end
            end
            chk("i_rand_done", ok, 1);
            bus.icache_read = 0;
        end
    endtask

    task automatic drive_d(input int n);
        int kind;
        bit ok;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            kind = $urandom_range(0, 9);
            bus.dcache_address = $urandom;
            bus.dcache_wdata   = rand_line();
            bus.dcache_read    = (kind < 5) || (kind == 9);
            bus.dcache_write   = (kind >= 5);
            ok = 0;
            for (int c = 0; c < 100; c++) begin
                @(posedge clk); #1;
                if (bus.dcache_resp) begin ok = 1; break; end
            end
            chk("d_rand_done", ok, 1);
            bus.dcache_read = 0;
            bus.dcache_write = 0;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin : main
        int rd, wr, lat, d_at, i_at, g0, n, sp;
        bus.icache_read = 0; bus.icache_address = '0;
        bus.dcache_read = 0; bus.dcache_write = 0; bus.dcache_address = '0; bus.dcache_wdata = '0;
        do_reset();

        // I-cache alone, memory answers on the third strobe cycle
        fill_fixed = 1; fixed_line = {32{8'hA5}}; force_lat = 3;
        bus.icache_address = 32'h0000_0040; bus.icache_read = 1;
        run_txn(0, 30, rd, wr, lat);
        chk("ialone_read_cycles", rd, 3);
        chk("ialone_write_cycles", wr, 0);
        chk("ialone_resp_cycle", lat, 4);
        chk("ialone_rdata", bus.icache_rdata, {32{8'hA5}});
        fill_fixed = 0;
        @(posedge clk); #1;

        // D-cache write-back, one-cycle memory
        force_lat = 1;
        bus.dcache_address = 32'h100; bus.dcache_wdata = {8{32'h1234_5678}}; bus.dcache_write = 1;
        run_txn(1, 30, rd, wr, lat);
        chk("dwr_write_cycles", wr, 1);
        chk("dwr_read_cycles", rd, 0);
        chk("dwr_resp_cycle", lat, 2);
        @(posedge clk); #1;

        // Tie straight out of reset: D first, I in the IDLE after D's resp
        do_reset();
        bus.icache_address = 32'h80; bus.dcache_address = 32'h1C0;
        bus.icache_read = 1; bus.dcache_read = 1;
        d_at = -1; i_at = -1;
        for (int c = 1; c <= 30 && i_at < 0; c++) begin
            @(posedge clk); #1;
            if (bus.dcache_resp && d_at < 0) begin d_at = c; bus.dcache_read = 0; end
            if (bus.icache_resp) i_at = c;
        end
        bus.icache_read = 0; bus.dcache_read = 0;
        chk("tie_d_resp_cycle", d_at, 2);
        chk("tie_i_resp_cycle", i_at, 5);
        @(posedge clk); #1;

        // Alternation: both re-request immediately after each resp
        force_lat = 0;
        g0 = glog.size();
        bus.icache_address = 32'h400; bus.dcache_address = 32'h800;
        bus.icache_read = 1; bus.dcache_read = 1;
        for (int c = 0; c < 300 && (bus.icache_read || bus.dcache_read); c++) begin
            @(posedge clk); #1;
            if (bus.icache_resp) begin
                if (glog.size() - g0 < 4) bus.icache_address += 32'h20; else bus.icache_read = 0;
            end
            if (bus.dcache_resp) begin
                if (glog.size() - g0 < 4) bus.dcache_address += 32'h20; else bus.dcache_read = 0;
            end
        end
        bus.icache_read = 0; bus.dcache_read = 0;
        chk("alt_enough_grants", glog.size() - g0 >= 4, 1);
        for (int k = 0; k < 4; k++)
            if (glog.size() > g0 + k) chk($sformatf("alt_grant_%0d_is_d", k), glog[g0 + k], (k % 2 == 0) ? 1 : 0);
        @(posedge clk); #1;

        // Reset two cycles into a D-cache read, then re-grant
        force_lat = 10;
        bus.dcache_address = 32'h300; bus.dcache_read = 1;
        repeat (2) begin @(posedge clk); #1; end
        chk("rmid_strobe_before_rst", bus.pmem_read, 1);
        rst = 1; #1;
        chk("rmid_strobe_drops", bus.pmem_read, 0);
        n = 0;
        repeat (2) begin @(posedge clk); #1; n += int'(bus.dcache_resp); end
        chk("rmid_no_resp", n, 0);
        rst = 0; force_lat = 2;
        run_txn(1, 30, rd, wr, lat);
        chk("rmid_regrant_read_cycles", rd, 2);
        chk("rmid_regrant_resp_cycle", lat, 3);
        @(posedge clk); #1;

        // Spurious pmem_resp while idle, then read+write together
        spur_pct = 100;
        n = 0; sp = 0;
        repeat (10) begin
            @(posedge clk); #1;
            n += int'(bus.icache_resp) + int'(bus.dcache_resp);
            sp += int'(bus.pmem_resp);
        end
        chk("spur_no_resp", n, 0);
        chk("spur_pulses_seen", sp > 0, 1);
        force_lat = 1;
        bus.dcache_address = 32'h240; bus.dcache_wdata = rand_line();
        bus.dcache_read = 1; bus.dcache_write = 1;
        run_txn(1, 30, rd, wr, lat);
        chk("rw_both_read_cycles", rd, 0);
        chk("rw_both_write_cycles", wr, 1);
        chk("rw_both_resp_cycle", lat, 2);
        @(posedge clk); #1;

        // Random traffic from both caches
        spur_pct = 25; force_lat = 0;
        fork
            drive_i(40);
            drive_d(40);
        join
        repeat (4) begin @(posedge clk); #1; end
        chk("scoreboard_drained", iq.size() + dq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
